// File: rtl/double_buffer_reader.sv
// Sweeps a published doubleBuffer bank and streams it out over valid/ready.
// Define DOUBLE_BUFFER_READER_HEADER_EN to prefix every frame with a length header word.
module double_buffer_reader #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned OVERRUN_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     newData,
  input  logic [ADDRESS_WIDTH-1:0] dataLength,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic [ADDRESS_WIDTH-1:0] readPointer,
  output logic [DATA_WIDTH-1:0]    outData,
  output logic                     outValid,
  input  logic                     outReady,
  output logic                     outLast,
  output logic                     busy,
  output logic                     done,
  output logic [OVERRUN_WIDTH-1:0] overrun
);

`ifdef DOUBLE_BUFFER_READER_HEADER_EN
  if (DATA_WIDTH < ADDRESS_WIDTH) begin : gen_width_check
    $error("double_buffer_reader: DATA_WIDTH must be >= ADDRESS_WIDTH for the header word");
  end
`endif

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPresent,
    StFinish,
    StHeader
  } state_e;

  state_e                   state, stateNext;
  logic                     newDataQ;
  logic                     trigger;
  logic [ADDRESS_WIDTH-1:0] len, lenNext;
  logic [ADDRESS_WIDTH-1:0] readPointerNext;
  logic [DATA_WIDTH-1:0]    outDataNext;
  logic                     outValidNext;
  logic                     outLastNext;
  logic                     busyNext;
  logic                     doneNext;
  logic [OVERRUN_WIDTH-1:0] overrunNext;

  assign trigger = newData & ~newDataQ;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      newDataQ    <= 1'b0;
      len         <= '0;
      readPointer <= '0;
      outData     <= '0;
      outValid    <= 1'b0;
      outLast     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= '0;
    end else begin
      state       <= stateNext;
      newDataQ    <= newData;
      len         <= lenNext;
      readPointer <= readPointerNext;
      outData     <= outDataNext;
      outValid    <= outValidNext;
      outLast     <= outLastNext;
      busy        <= busyNext;
      done        <= doneNext;
      overrun     <= overrunNext;
    end
  end

  always_comb begin
    stateNext       = state;
    lenNext         = len;
    readPointerNext = readPointer;
    outDataNext     = outData;
    outValidNext    = outValid;
    outLastNext     = outLast;
    busyNext        = busy;
    doneNext        = 1'b0;
    overrunNext     = overrun;

    // Any trigger outside IDLE (FINISH included) is dropped and counted.
    if (trigger && (state != StIdle) && (overrun != '1)) begin
      overrunNext = overrun + OVERRUN_WIDTH'(1);
    end

    unique case (state)
      StIdle: begin
        if (trigger) begin
          lenNext = dataLength;
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
          busyNext     = 1'b1;
          outDataNext  = DATA_WIDTH'(dataLength);
          outValidNext = 1'b1;
          outLastNext  = (dataLength == '0);
          stateNext    = StHeader;
          if (dataLength != '0) begin
            readPointerNext = '0;
          end
`else
          if (dataLength == '0) begin
            stateNext = StFinish;
          end else begin
            readPointerNext = '0;
            busyNext        = 1'b1;
            stateNext       = StFetch;
          end
`endif
        end
      end
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
      StHeader: begin
        if (outReady) begin
          outValidNext = 1'b0;
          outLastNext  = 1'b0;
          stateNext    = outLast ? StFinish : StFetch;
        end
      end
`endif
      StFetch: begin
        outDataNext  = dataIn;
        outValidNext = 1'b1;
        outLastNext  = (readPointer == len - ADDRESS_WIDTH'(1));
        stateNext    = StPresent;
      end
      StPresent: begin
        if (outReady) begin
          outValidNext    = 1'b0;
          outLastNext     = 1'b0;
          readPointerNext = readPointer + ADDRESS_WIDTH'(1);
          stateNext       = outLast ? StFinish : StFetch;
        end
      end
      StFinish: begin
        doneNext  = 1'b1;
        busyNext  = 1'b0;
        stateNext = StIdle;
      end
      default: stateNext = StIdle;
    endcase
  end

endmodule

// File: tb/tb_double_buffer_reader.sv
// Directed bench for double_buffer_reader with a small doubleBuffer read model.
// Define DOUBLE_BUFFER_READER_HEADER_EN for both files to exercise the header variant.
module tb_double_buffer_reader;
  localparam int DW = 4;
  localparam int AW = 2;
  localparam int OW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          newData = 1'b0;
  logic [AW-1:0] dataLength = '0;
  logic [DW-1:0] dataIn;
  logic [AW-1:0] readPointer;
  logic [DW-1:0] outData;
  logic          outValid;
  logic          outReady = 1'b1;
  logic          outLast;
  logic          busy;
  logic          done;
  logic [OW-1:0] overrun;

  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int doneCount = 0;
  bit busySeen = 0;
  bit validSeen = 0;
  bit stallPrev = 0;
  logic [DW:0] stallWord;
  logic [DW:0] words [$];
  int hsCycle [$];

  double_buffer_reader #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .OVERRUN_WIDTH(OW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .newData    (newData),
    .dataLength (dataLength),
    .dataIn     (dataIn),
    .readPointer(readPointer),
    .outData    (outData),
    .outValid   (outValid),
    .outReady   (outReady),
    .outLast    (outLast),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Registered read: address launched at one rising edge is ready for the next.
  always @(negedge clock) dataIn <= mem[readPointer];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      if (stallPrev) begin
        checkEq("stall_valid", {31'd0, outValid}, 32'd1);
        checkEq("stall_word", {27'd0, outLast, outData}, {27'd0, stallWord});
      end
      stallPrev = outValid && !outReady;
      stallWord = {outLast, outData};
      if (outValid && outReady) begin
        words.push_back({outLast, outData});
        hsCycle.push_back(cyc);
      end
      if (done) doneCount++;
      if (busy) busySeen = 1;
      if (outValid) validSeen = 1;
    end else begin
      stallPrev = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    words.delete();
    hsCycle.delete();
    busySeen = 0;
    validSeen = 0;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n = 0;
    int start = doneCount;
    while (doneCount == start && n < budget) begin
      tick();
      n++;
    end
    checkEq(tag, doneCount - start, 1);
  endtask

  task automatic expectWords(input string tag, input int n, input logic [DW:0] e0,
                             input logic [DW:0] e1, input logic [DW:0] e2,
                             input logic [DW:0] e3);
    logic [DW:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    checkEq({tag, "_count"}, words.size(), n);
    for (int i = 0; i < n && i < words.size(); i++) begin
      checkEq($sformatf("%s_w%0d", tag, i), {27'd0, words[i]}, {27'd0, e[i]});
    end
  endtask

  initial begin
    int d0;
    mem[0] = 4'h0; mem[1] = 4'h0; mem[2] = 4'h0; mem[3] = 4'h0;
    tick();
    tick();
    checkEq("rst_rp", readPointer, 0);
    checkEq("rst_data", outData, 0);
    checkEq("rst_valid", outValid, 0);
    checkEq("rst_last", outLast, 0);
    checkEq("rst_busy", busy, 0);
    checkEq("rst_done", done, 0);
    checkEq("rst_overrun", overrun, 0);
    reset = 1'b1;
    tick();

    // Full-rate frame {4,5,6}.
    mem[0] = 4'h4; mem[1] = 4'h5; mem[2] = 4'h6;
    dataLength = 3;
    outReady = 1'b1;
    clearLog();
    newData = 1'b1;
    tick();
    checkEq("t1_busy", busy, 1);
    waitDone(30, "t1_done");
    checkEq("t1_busy_end", busy, 0);
    checkEq("t1_rp", readPointer, 3);
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t1", 4, {1'b0, 4'h3}, {1'b0, 4'h4}, {1'b0, 4'h5}, {1'b1, 4'h6});
    checkEq("t1_gap", hsCycle[3] - hsCycle[2], 2);
`else
    expectWords("t1", 3, {1'b0, 4'h4}, {1'b0, 4'h5}, {1'b1, 4'h6}, '0);
    checkEq("t1_gap0", hsCycle[1] - hsCycle[0], 2);
    checkEq("t1_gap1", hsCycle[2] - hsCycle[1], 2);
`endif
    d0 = doneCount;
    tick();
    tick();
    checkEq("t1_done_once", doneCount - d0, 0);
    newData = 1'b0;
    tick();

    // Same frame with outReady toggling every 3 cycles.
    clearLog();
    d0 = doneCount;
    newData = 1'b1;
    for (int k = 0; k < 60 && doneCount == d0; k++) begin
      outReady = ((k / 3) % 2) == 1;
      tick();
    end
    checkEq("t2_done", doneCount - d0, 1);
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t2", 4, {1'b0, 4'h3}, {1'b0, 4'h4}, {1'b0, 4'h5}, {1'b1, 4'h6});
`else
    expectWords("t2", 3, {1'b0, 4'h4}, {1'b0, 4'h5}, {1'b1, 4'h6}, '0);
`endif
    checkEq("t2_rp", readPointer, 3);
    newData = 1'b0;
    outReady = 1'b1;
    tick();

    // Empty frame.
    dataLength = 0;
    clearLog();
    newData = 1'b1;
    tick();
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    checkEq("t3_hdr_valid", outValid, 1);
    checkEq("t3_hdr_last", outLast, 1);
    waitDone(10, "t3_done");
    expectWords("t3", 1, {1'b1, 4'h0}, '0, '0, '0);
`else
    checkEq("t3_done_early", done, 0);
    checkEq("t3_busy", busy, 0);
    tick();
    checkEq("t3_done", done, 1);
    tick();
    checkEq("t3_done_end", done, 0);
    checkEq("t3_busy_seen", busySeen, 0);
    checkEq("t3_valid_seen", validSeen, 0);
`endif
    checkEq("t3_rp", readPointer, 3);
    newData = 1'b0;
    tick();

    // Overrun while streaming {8,9,a}.
    mem[0] = 4'h8; mem[1] = 4'h9; mem[2] = 4'ha;
    dataLength = 3;
    clearLog();
    newData = 1'b1;
    tick();
    tick();
    tick();
    newData = 1'b0;
    tick();
    newData = 1'b1;
    tick();
    checkEq("t4_overrun1", overrun, 1);
    waitDone(30, "t4_done");
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t4", 4, {1'b0, 4'h3}, {1'b0, 4'h8}, {1'b0, 4'h9}, {1'b1, 4'ha});
`else
    expectWords("t4", 3, {1'b0, 4'h8}, {1'b0, 4'h9}, {1'b1, 4'ha}, '0);
`endif
    newData = 1'b0;
    tick();

    // Saturation: stall a frame and fire 256 more triggers.
    outReady = 1'b0;
    clearLog();
    newData = 1'b1;
    tick();
    for (int i = 0; i < 253; i++) begin
      newData = 1'b0;
      tick();
      newData = 1'b1;
      tick();
    end
    checkEq("t4_overrun254", overrun, 254);
    for (int i = 0; i < 3; i++) begin
      newData = 1'b0;
      tick();
      newData = 1'b1;
      tick();
    end
    checkEq("t4_overrun_sat", overrun, 255);
    outReady = 1'b1;
    waitDone(30, "t4_sat_done");
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t4s", 4, {1'b0, 4'h3}, {1'b0, 4'h8}, {1'b0, 4'h9}, {1'b1, 4'ha});
`else
    expectWords("t4s", 3, {1'b0, 4'h8}, {1'b0, 4'h9}, {1'b1, 4'ha}, '0);
`endif
    newData = 1'b0;
    tick();

    // Reset while word 9 is presented, then a clean frame {c,d,e}.
    clearLog();
    newData = 1'b1;
    for (int k = 0; k < 20 && !(outValid && outData == 4'h9); k++) tick();
    checkEq("t5_word9", outData, 4'h9);
    d0 = doneCount;
    #2;
    reset = 1'b0;
    newData = 1'b0;
    #1;
    checkEq("t5_valid", outValid, 0);
    checkEq("t5_busy", busy, 0);
    checkEq("t5_rp", readPointer, 0);
    checkEq("t5_overrun", overrun, 0);
    tick();
    reset = 1'b1;
    tick();
    checkEq("t5_no_done", doneCount - d0, 0);
    mem[0] = 4'hc; mem[1] = 4'hd; mem[2] = 4'he;
    clearLog();
    newData = 1'b1;
    waitDone(30, "t5_done");
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t5", 4, {1'b0, 4'h3}, {1'b0, 4'hc}, {1'b0, 4'hd}, {1'b1, 4'he});
`else
    expectWords("t5", 3, {1'b0, 4'hc}, {1'b0, 4'hd}, {1'b1, 4'he}, '0);
`endif
    checkEq("t5_rp_end", readPointer, 3);
    newData = 1'b0;
    tick();

    // Two-entry frame {1,3}.
    mem[0] = 4'h1; mem[1] = 4'h3;
    dataLength = 2;
    clearLog();
    newData = 1'b1;
    waitDone(30, "t6_done");
`ifdef DOUBLE_BUFFER_READER_HEADER_EN
    expectWords("t6", 3, {1'b0, 4'h2}, {1'b0, 4'h1}, {1'b1, 4'h3}, '0);
`else
    expectWords("t6", 2, {1'b0, 4'h1}, {1'b1, 4'h3}, '0, '0);
`endif
    checkEq("t6_rp", readPointer, 2);
    newData = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/double_buffer_reader.md
Name: double_buffer_reader

Overview:
- Consumer stage directly downstream of doubleBuffer, in the readClock domain.
- On each newData rising edge it sweeps readPointer over the published bank, entries 0..dataLength-1.
- It absorbs the buffer's one-cycle registered read latency and presents each entry on a valid/ready stream (outData/outValid/outReady/outLast) toward the host link.
- When the sweep ends, readPointer parks at dataLength, which the producer side waits on before the next switch.

Parameters:
DATA_WIDTH, 16, width of one buffer entry and of outData
ADDRESS_WIDTH, 8, width of readPointer/dataLength; max frame = 2^ADDRESS_WIDTH-1 entries
OVERRUN_WIDTH, 8, width of saturating overrun counter

Ports:
clock  input  1  single clock (doubleBuffer readClock)
reset  input  1  asynchronous, active-low reset
newData  input  1  level from doubleBuffer; rising edge = new bank published
dataLength  input  ADDRESS_WIDTH  entry count of published bank
dataIn  input  DATA_WIDTH  doubleBuffer dataOut, valid 1 cycle after readPointer
readPointer  output  ADDRESS_WIDTH  read address into doubleBuffer
outData  output  DATA_WIDTH  stream data
outValid  output  1  stream valid
outReady  input  1  downstream ready
outLast  output  1  marks final word of frame, qualified by outValid
busy  output  1  high from accepted trigger until frame finished
done  output  1  one-cycle pulse when frame finished (incl. empty frame)
overrun  output  OVERRUN_WIDTH  saturating count of triggers ignored while busy

Behaviour:
- Reset (reset=0, async): readPointer=0, outData=0, outValid=0, outLast=0, busy=0, done=0, overrun=0, state=IDLE, newData edge register=0.
- Edge detect: newData is registered; trigger = newData & ~newDataQ. A level held high does not retrigger.
- FSM states: IDLE, FETCH, PRESENT, FINISH.
- IDLE:
  - On trigger, latch len=dataLength.
  - If len==0: go to FINISH; readPointer stays at its current value.
  - Else: readPointer<=0, busy<=1, go to FETCH.
- FETCH: one wait cycle for read latency. Next cycle: outData<=dataIn, outValid<=1, outLast<=(readPointer==len-1), go to PRESENT.
- PRESENT:
  - Hold outData/outValid/outLast stable until outValid&outReady.
  - On handshake: outValid<=0, readPointer<=readPointer+1.
  - Then go to FINISH if the word was last, else FETCH.
  - Throughput: 1 word per 2 cycles with outReady held high.
- FINISH: done<=1 for one cycle, busy<=0, go to IDLE. readPointer equals len on exit.
- Trigger while not IDLE: ignored, and overrun increments, saturating at all-ones. A trigger in the same cycle as FINISH is also ignored and counted.
- dataLength changing mid-frame has no effect; len is latched.
- readPointer arithmetic is modulo 2^ADDRESS_WIDTH. The maximum len=2^ADDRESS_WIDTH-1 ends with readPointer=len, so there is no wrap.
- Asserting reset mid-frame aborts immediately. No done pulse; the partial frame is discarded downstream by the absence of outLast.
- outReady low never stalls the doubleBuffer write side. The producer stalls only via its own wait on readPointer==dataLength.

Optional Feature:
- Macro: DOUBLE_BUFFER_READER_HEADER_EN.
- When defined:
  - Each accepted trigger first emits a header word: outData = len zero-extended to DATA_WIDTH, outLast=0, via an extra HEADER state before FETCH.
  - For len==0, the header is emitted with outLast=1, then FINISH.
  - Requires DATA_WIDTH >= ADDRESS_WIDTH, checked by an elaboration-time error.
- When undefined: no header; empty frames emit nothing.

Test Plan (DATA_WIDTH=4, ADDRESS_WIDTH=2, doubleBuffer model driving dataIn one cycle after readPointer):
- Bank {4,5,6}, dataLength=3, newData rise, outReady=1 -> outData 4,5,6 on consecutive handshakes 2 cycles apart; outLast only on 6; done pulses once; readPointer=3 afterwards.
- Same bank, outReady toggled 0/1 every 3 cycles -> outData stays stable while outValid&~outReady; sequence still 4,5,6; no duplicates or drops.
- dataLength=0, newData rise -> no outValid, done pulses 1 cycle after trigger, busy never rises; with HEADER_EN, a single word 0 with outLast=1.
- Second newData rise while streaming the {8,9,a} bank -> overrun=1, frame completes normally; 256 such triggers with OVERRUN_WIDTH=8 -> overrun saturates at 255.
- reset driven low while in PRESENT on word 9 -> outValid=0, busy=0, readPointer=0 immediately; next trigger with bank {c,d,e} streams c,d,e correctly.
- HEADER_EN defined, bank {1,3}, dataLength=2 -> outData 2,1,3 with outLast only on 3.
